// File: rtl/switch_out_arbiter_pkg.sv
//==============================================================================
// Module      : switch_out_arbiter_pkg
// Description : Shared port-index/mask types, arbiter state encoding and the
//               round-robin pointer advance helper for switch_out_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package switch_out_arbiter_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SRC_W     = $clog2(NUM_PORTS);

    typedef logic [SRC_W-1:0]     port_idx_t;
    typedef logic [NUM_PORTS-1:0] port_mask_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_e;

    // Pointer to the requester after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/switch_out_arbiter_if.sv
//==============================================================================
// Module      : switch_out_arbiter_if
// Description : Ingress request bus, pop strobes and egress handshake for one
//               egress port. Statistics signals exist only with
//               SWITCH_ARB_STATS_EN defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface switch_out_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int SRC_W     = 2
`ifdef SWITCH_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
);
    logic [NUM_PORTS-1:0]           req_valid;
    logic [NUM_PORTS*SRC_W-1:0]     req_source;
    logic [NUM_PORTS*NUM_PORTS-1:0] req_target;
    logic [NUM_PORTS*DATA_W-1:0]    req_data;
    logic [NUM_PORTS-1:0]           gnt;
    logic                           out_valid;
    logic                           out_ready;
    logic [SRC_W-1:0]               out_source;
    logic [NUM_PORTS-1:0]           out_target;
    logic [DATA_W-1:0]              out_data;
`ifdef SWITCH_ARB_STATS_EN
    logic [NUM_PORTS*CNT_W-1:0]     stat_gnt_cnt;
    logic [CNT_W-1:0]               stat_stall;

    modport master (
        input  req_valid, req_source, req_target, req_data, out_ready,
        output gnt, out_valid, out_source, out_target, out_data,
        output stat_gnt_cnt, stat_stall
    );

    modport slave (
        output req_valid, req_source, req_target, req_data, out_ready,
        input  gnt, out_valid, out_source, out_target, out_data,
        input  stat_gnt_cnt, stat_stall
    );
`else
    modport master (
        input  req_valid, req_source, req_target, req_data, out_ready,
        output gnt, out_valid, out_source, out_target, out_data
    );

    modport slave (
        output req_valid, req_source, req_target, req_data, out_ready,
        input  gnt, out_valid, out_source, out_target, out_data
    );
`endif

endinterface

`default_nettype wire

// File: rtl/switch_out_arbiter_rr_picker.sv
//==============================================================================
// Module      : switch_out_arbiter_rr_picker
// Description : Combinational round-robin picker: first eligible requester
//               scanning upward from the pointer, modulo N.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_out_arbiter_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     i_eligible,
    input  wire logic [IDX_W-1:0] i_rr_ptr,
    output logic                  o_any,
    output logic [N-1:0]          o_winner_oh,
    output logic [IDX_W-1:0]      o_winner_idx
);

    always_comb begin
        o_any        = 1'b0;
        o_winner_oh  = '0;
        o_winner_idx = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(i_rr_ptr) + k) % N;
            if (!o_any && i_eligible[j]) begin
                o_any          = 1'b1;
                o_winner_oh[j] = 1'b1;
                o_winner_idx   = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/switch_out_arbiter.sv
//==============================================================================
// Module      : switch_out_arbiter
// Description : Per-egress round-robin arbiter and output register. Optional
//               grant/stall counters enabled by SWITCH_ARB_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_out_arbiter
    import switch_out_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_ID   = 0,
    parameter int DATA_W    = 8,
    parameter int SRC_W     = 2
`ifdef SWITCH_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input wire logic              clk,
    input wire logic              rst,
    switch_out_arbiter_if.master  bus
);

    localparam int c_idx_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] c_st_idle = ARB_IDLE;
    localparam logic [0:0] c_st_send = ARB_SEND;

    logic [0:0]           r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [SRC_W-1:0]     r_out_source;
    logic [NUM_PORTS-1:0] r_out_target;
    logic [DATA_W-1:0]    r_out_data;

    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_winner_oh;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [c_idx_w-1:0]   w_winner_idx;
    logic                 w_any;
    logic                 w_load;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
        assign w_eligible[i] = bus.req_valid[i] & bus.req_target[i*NUM_PORTS + PORT_ID];
    end

    switch_out_arbiter_rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (c_idx_w)
    ) u_picker (
        .i_eligible   (w_eligible),
        .i_rr_ptr     (r_rr_ptr),
        .o_any        (w_any),
        .o_winner_oh  (w_winner_oh),
        .o_winner_idx (w_winner_idx)
    );

    // Gating on rst keeps the ingress from popping a packet that reset will drop.
    assign w_load = !rst && w_any && ((r_state == c_st_idle) || bus.out_ready);
    assign w_gnt  = w_load ? w_winner_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_rr_ptr     <= '0;
            r_out_source <= '0;
            r_out_target <= '0;
            r_out_data   <= '0;
        end else if (w_load) begin
            r_state      <= c_st_send;
            r_rr_ptr     <= c_idx_w'(rr_next(int'(w_winner_idx), NUM_PORTS));
            r_out_source <= bus.req_source[int'(w_winner_idx)*SRC_W +: SRC_W];
            r_out_target <= bus.req_target[int'(w_winner_idx)*NUM_PORTS +: NUM_PORTS];
            r_out_data   <= bus.req_data[int'(w_winner_idx)*DATA_W +: DATA_W];
        end else if ((r_state == c_st_send) && bus.out_ready) begin
            r_state      <= c_st_idle;
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.out_valid  = (r_state == c_st_send);
    assign bus.out_source = r_out_source;
    assign bus.out_target = r_out_target;
    assign bus.out_data   = r_out_data;

`ifdef SWITCH_ARB_STATS_EN
    logic [CNT_W-1:0] r_stall;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat_gnt
        logic [CNT_W-1:0] r_gnt_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_gnt_cnt <= '0;
            end else if (w_gnt[i] && (r_gnt_cnt != '1)) begin
                r_gnt_cnt <= r_gnt_cnt + 1'b1;
            end
        end
        assign bus.stat_gnt_cnt[i*CNT_W +: CNT_W] = r_gnt_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == c_st_send) && !bus.out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.stat_stall = r_stall;
`endif

endmodule

`default_nettype wire
